bc_polinomio: RTL and testbench
===============================

Name: bc_polinomio

Overview:
- Control block (FSM) that sequences the polynomial datapath BO: registers R0 (x), R1 (LH), R2 (LS), muxes M0/M1/M2 and the add/multiply unit.
- Computes y = A*x^2 + B*x + C in quadratic mode, or y = B*x + C in linear mode.
- Result is left in R2, which drives BO's Pronto output.
- Sits beside BO. All BO control inputs are driven only by this block. Host uses a start/fim handshake.

Parameters:
- WAIT_CYC, 0, extra hold cycles per compute step, for a slow or registered ULA path; range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a computation; sampled only in IDLE
- modo  in  1  0 = quadratic, 1 = linear; latched with start
- M0  out  2  BO M0 select: 00 zero, 01 A, 10 B, 11 C
- M1  out  2  BO M1 select: 00 saidaM0, 01 R0, 10 R2, 11 R1
- M2  out  2  BO M2 select: 00 R0, 01 saidaM0, 10 R2, 11 R1
- LX  out  1  load R0 with x
- LH  out  1  load R1 with ULA result
- LS  out  1  load R2 with ULA result
- H  out  1  ULA op: 1 multiply, 0 add
- busy  out  1  high from LOADX through DONE inclusive
- fim  out  1  one-cycle pulse; R2 holds a valid result

Behaviour:
- Reset (synchronous, active-high): at the rst edge, state = IDLE and step counter = 0.
  - All outputs are 0 in the cycle after that edge.
  - rst mid-operation aborts immediately, with no further load strobes.
  - BO's own rst is separate and is not driven here.
- Outputs are Moore outputs decoded from the state register. In every state, any output not listed below is 0.
- IDLE: waits for start.
  - If start=1 at edge k: latch modo and go to LOADX for cycle k+1.
- LOADX (1 cycle): LX=1. Next state is XX in quadratic mode, BX in linear mode.
- Compute steps. Each lasts WAIT_CYC+1 cycles:
  - Selects and H are held for the whole step.
  - LH/LS are asserted only in the last cycle of the step (counter == WAIT_CYC).
  - The counter returns to 0 when the step advances.
- Step definitions:
  - XX: M1=01, M2=00, H=1, LH on last cycle. Result R1 = x*x.
  - AXX: M0=01, M1=00, M2=11, H=1, LH on last cycle. Result R1 = A*R1.
  - BX: M0=10, M1=00, M2=00, H=1, LS on last cycle. Result R2 = B*x.
  - SUM1 (quadratic only): M1=10, M2=11, H=0, LS on last cycle. Result R2 = R2 + R1.
  - SUMC: M0=11, M1=10, M2=01, H=0, LS on last cycle. Result R2 = R2 + C.
- Step order:
  - Quadratic: XX, AXX, BX, SUM1, SUMC, DONE.
  - Linear: BX, SUMC, DONE.
- DONE (1 cycle): fim=1, busy=1, then return to IDLE.
- Latency from the start edge k to the fim cycle:
  - Quadratic: k + 2 + 5*(WAIT_CYC+1). With WAIT_CYC=0 this is k+7.
  - Linear: k + 2 + 2*(WAIT_CYC+1). With WAIT_CYC=0 this is k+4.
- start while busy (including the DONE cycle) is ignored. There is no queueing.
- start held high continuously: a new computation begins on the IDLE cycle after DONE. There is one IDLE cycle between runs.
- modo changes while busy have no effect.
- Arithmetic width and overflow are owned by BO (16-bit wrap). This block does no arithmetic.
- Invariants:
  - At most one of LX/LH/LS is high in any cycle.
  - No load strobe is high in IDLE or DONE.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, LOADX, XX, AXX, BX, SUM1, SUMC, DONE (3-bit).
  - Mux select constants: SEL_M0_ZERO/A/B/C, SEL_M1_M0/R0/R2/R1, SEL_M2_R0/M0/R2/R1.
  - H_MUL=1, H_ADD=0.
- One sub-module, passo_contador: 4-bit step-hold counter.
  - Inputs: clear, enable.
  - Outputs: last = (count == WAIT_CYC).
- FSM and output decode stay in bc_polinomio.

Test Plan:
1. Quadratic run: BO integrated, A=1, B=2, C=2, x=2, WAIT_CYC=0, start pulse at edge k.
   -> busy rises at k+1; fim high only at k+7; Pronto = 10; R1 = 4.
2. Linear run: same operands, modo=1.
   -> fim at k+4; Pronto = 6; the cycle sequence never asserts LH.
3. WAIT_CYC=2, quadratic, A=3, B=0, C=5, x=3.
   -> fim at k+17; Pronto = 32; each step holds its selects for 3 cycles, with a load strobe only in the 3rd.
4. start pulsed during SUM1, and start held high for 20 cycles.
   -> The mid-run pulse is ignored. With start held, exactly one IDLE cycle separates fim from the next LOADX.
5. rst asserted during AXX, then start again.
   -> The next cycle is IDLE with all outputs 0 and no LS. The new run completes with the correct result.
6. Strobe-exclusivity monitor across all runs.
   -> Never more than one of LX/LH/LS high; fim is never high without busy.

Source files
------------

// File: rtl/bc_polinomio_pkg.sv
// Shared types and constants for the polynomial control block.
// State encoding, BO mux selects and ULA op codes.
package bc_polinomio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADX,
        XX,
        AXX,
        BX,
        SUM1,
        SUMC,
        DONE
    } estado_t;

    localparam logic [1:0] SEL_M0_ZERO = 2'b00;
    localparam logic [1:0] SEL_M0_A    = 2'b01;
    localparam logic [1:0] SEL_M0_B    = 2'b10;
    localparam logic [1:0] SEL_M0_C    = 2'b11;

    localparam logic [1:0] SEL_M1_M0 = 2'b00;
    localparam logic [1:0] SEL_M1_R0 = 2'b01;
    localparam logic [1:0] SEL_M1_R2 = 2'b10;
    localparam logic [1:0] SEL_M1_R1 = 2'b11;

    localparam logic [1:0] SEL_M2_R0 = 2'b00;
    localparam logic [1:0] SEL_M2_M0 = 2'b01;
    localparam logic [1:0] SEL_M2_R2 = 2'b10;
    localparam logic [1:0] SEL_M2_R1 = 2'b11;

    localparam logic H_MUL = 1'b1;
    localparam logic H_ADD = 1'b0;

    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       lh;
        logic       ls;
        logic       h;
        logic       busy;
        logic       fim;
    } ctrl_t;

endpackage

// File: rtl/bc_polinomio_if.sv
// Host handshake plus BO control bundle of the polynomial control block.
// The control block is the slave side; host/BO use the master side.
interface bc_polinomio_if;
    logic       start;
    logic       modo;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
    logic       LX;
    logic       LH;
    logic       LS;
    logic       H;
    logic       busy;
    logic       fim;

    modport master (
        output start, modo,
        input  M0, M1, M2, LX, LH, LS, H, busy, fim
    );

    modport slave (
        input  start, modo,
        output M0, M1, M2, LX, LH, LS, H, busy, fim
    );
endinterface

// File: rtl/bc_polinomio_passo_contador.sv
// Step-hold counter: stretches each compute step to WAIT_CYC+1 cycles.
module passo_contador #(
    parameter int WAIT_CYC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [3:0] LIM = 4'(WAIT_CYC);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 4'd1;
    end

    assign last = (cnt == LIM);

endmodule

// File: rtl/bc_polinomio.sv
// Control FSM sequencing the BO datapath for y = A*x^2 + B*x + C
// (quadratic) or y = B*x + C (linear); result is left in R2.
module bc_polinomio
    import bc_polinomio_pkg::*;
#(
    parameter int WAIT_CYC = 0
) (
    input  logic           clk,
    input  logic           rst,
    bc_polinomio_if.slave  bus
);

    estado_t st, nxt;
    ctrl_t   c;
    logic    modo_q;
    logic    last;
    logic    clr;
    logic    en;

    passo_contador #(.WAIT_CYC(WAIT_CYC)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (clr),
        .enable (en),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            modo_q <= 1'b0;
        end else begin
            st <= nxt;
            if (st == IDLE && bus.start)
                modo_q <= bus.modo;
        end
    end

    always_comb begin
        nxt = st;
        c   = '0;
        clr = 1'b1;
        en  = 1'b0;
        unique case (st)
            IDLE: begin
                if (bus.start)
                    nxt = LOADX;
            end
            LOADX: begin
                c.lx   = 1'b1;
                c.busy = 1'b1;
                nxt    = modo_q ? BX : XX;
            end
            XX: begin
                c.m1 = SEL_M1_R0;
                c.m2 = SEL_M2_R0;
                c.h  = H_MUL;
                c.lh = last;
                if (last) nxt = AXX;
            end
            AXX: begin
                c.m0 = SEL_M0_A;
                c.m1 = SEL_M1_M0;
                c.m2 = SEL_M2_R1;
                c.h  = H_MUL;
                c.lh = last;
                if (last) nxt = BX;
            end
            BX: begin
                c.m0 = SEL_M0_B;
                c.m1 = SEL_M1_M0;
                c.m2 = SEL_M2_R0;
                c.h  = H_MUL;
                c.ls = last;
                if (last) nxt = modo_q ? SUMC : SUM1;
            end
            SUM1: begin
                c.m1 = SEL_M1_R2;
                c.m2 = SEL_M2_R1;
                c.h  = H_ADD;
                c.ls = last;
                if (last) nxt = SUMC;
            end
            SUMC: begin
                c.m0 = SEL_M0_C;
                c.m1 = SEL_M1_R2;
                c.m2 = SEL_M2_M0;
                c.h  = H_ADD;
                c.ls = last;
                if (last) nxt = DONE;
            end
            DONE: begin
                c.busy = 1'b1;
                c.fim  = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
        // Counter runs only inside a compute step and clears as it advances
        if (st inside {XX, AXX, BX, SUM1, SUMC}) begin
            c.busy = 1'b1;
            clr    = last;
            en     = ~last;
        end
    end

    assign bus.M0   = c.m0;
    assign bus.M1   = c.m1;
    assign bus.M2   = c.m2;
    assign bus.LX   = c.lx;
    assign bus.LH   = c.lh;
    assign bus.LS   = c.ls;
    assign bus.H    = c.h;
    assign bus.busy = c.busy;
    assign bus.fim  = c.fim;

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio: two instances (WAIT_CYC 0 and 2) against a
// schedule model and a behavioural BO datapath model.
module tb_bc_polinomio;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic modo = 1'b0;

    always #5 clk = ~clk;

    bc_polinomio_if if0();
    bc_polinomio_if if2();

    assign if0.start = start;
    assign if0.modo  = modo;
    assign if2.start = start;
    assign if2.modo  = modo;

    bc_polinomio #(.WAIT_CYC(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bc_polinomio #(.WAIT_CYC(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // {M0,M1,M2,LX,LH,LS,H,busy,fim}
    logic [11:0] act[2];
    assign act[0] = {if0.M0, if0.M1, if0.M2, if0.LX, if0.LH, if0.LS,
                     if0.H, if0.busy, if0.fim};
    assign act[1] = {if2.M0, if2.M1, if2.M2, if2.LX, if2.LH, if2.LS,
                     if2.H, if2.busy, if2.fim};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wc[2] = '{0, 2};

    bit          run[2];
    int          pos[2];
    bit          md[2];
    logic [11:0] expv[2];
    logic [11:0] snap[2];
    logic [15:0] na, nb, nc, nx;
    logic [15:0] oa[2], ob[2], oc[2], ox[2], want[2];
    logic [15:0] r0[2], r1[2], r2[2], res[2];
    int          fimc[2];
    int          lhcnt = 0;
    bit          held = 1'b0;
    int          lastfim0 = -1;

    task automatic check(input string nm, input logic [31:0] a,
                         input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic int run_len(bit m, int w);
        return 2 + (m ? 2 : 5) * (w + 1);
    endfunction

    // Expected outputs at position p of a run (0 = LOADX, last = DONE)
    function automatic logic [11:0] vec_at(bit m, int w, int p);
        logic [11:0] v;
        int k, s;
        logic lst;
        v = '0;
        if (p == 0) begin
            v = 12'b000000_100010;
        end else if (p == run_len(m, w) - 1) begin
            v = 12'b000000_000011;
        end else begin
            k = (p - 1) / (w + 1);
            lst = (((p - 1) % (w + 1)) == w);
            s = m ? (k == 0 ? 2 : 4) : k;
            case (s)
                0: v = {2'b00, 2'b01, 2'b00, 1'b0, lst, 1'b0, 1'b1, 1'b1, 1'b0};
                1: v = {2'b01, 2'b00, 2'b11, 1'b0, lst, 1'b0, 1'b1, 1'b1, 1'b0};
                2: v = {2'b10, 2'b00, 2'b00, 1'b0, 1'b0, lst, 1'b1, 1'b1, 1'b0};
                3: v = {2'b00, 2'b10, 2'b11, 1'b0, 1'b0, lst, 1'b0, 1'b1, 1'b0};
                default:
                   v = {2'b11, 2'b10, 2'b01, 1'b0, 1'b0, lst, 1'b0, 1'b1, 1'b0};
            endcase
        end
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Schedule model
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                run[i] = 1'b0;
            end else if (run[i]) begin
                if (pos[i] == run_len(md[i], wc[i]) - 1) run[i] = 1'b0;
                else pos[i] = pos[i] + 1;
            end else if (start) begin
                run[i] = 1'b1;
                pos[i] = 0;
                md[i] = modo;
                oa[i] = na; ob[i] = nb; oc[i] = nc; ox[i] = nx;
                want[i] = modo ? 16'(nb * nx + nc)
                               : 16'(na * nx * nx + nb * nx + nc);
            end
            expv[i] = run[i] ? vec_at(md[i], wc[i], pos[i]) : 12'h000;
        end
    end

    // BO datapath model driven by the DUT strobes of the previous cycle
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [15:0] m0v, a, b, u;
            case (snap[i][11:10])
                2'b00: m0v = 16'd0;
                2'b01: m0v = oa[i];
                2'b10: m0v = ob[i];
                default: m0v = oc[i];
            endcase
            case (snap[i][9:8])
                2'b00: a = m0v;
                2'b01: a = r0[i];
                2'b10: a = r2[i];
                default: a = r1[i];
            endcase
            case (snap[i][7:6])
                2'b00: b = r0[i];
                2'b01: b = m0v;
                2'b10: b = r2[i];
                default: b = r1[i];
            endcase
            u = snap[i][2] ? 16'(a * b) : 16'(a + b);
            if (snap[i][5]) r0[i] = ox[i];
            if (snap[i][4]) r1[i] = u;
            if (snap[i][3]) r2[i] = u;
        end
    end

    // Compare process
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            snap[i] = act[i];
            if (cyc >= 2) begin
                check($sformatf("outs%0d", i), {20'd0, act[i]}, {20'd0, expv[i]});
                check($sformatf("inv%0d", i),
                      {30'd0, $countones(act[i][5:3]) <= 1,
                       !act[i][0] || act[i][1]}, 32'd3);
                if (i == 0 && act[0][4]) lhcnt++;
                if (i == 0 && held && act[0][5] && lastfim0 >= 0)
                    check("held_gap", cyc - lastfim0, 2);
                if (act[i][0]) begin
                    check($sformatf("pronto%0d", i), {16'd0, r2[i]}, {16'd0, want[i]});
                    res[i] = r2[i];
                    fimc[i] = cyc;
                    if (i == 0) lastfim0 = cyc;
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((run[0] || run[1]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle actual=timeout required=idle");
        end
        @(negedge clk);
    endtask

    task automatic kick(input bit m, output int s);
        start = 1'b1;
        modo = m;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        modo = ~m;
    endtask

    initial begin
        int s;
        for (int i = 0; i < 2; i++) begin
            r0[i] = 0; r1[i] = 0; r2[i] = 0;
            oa[i] = 0; ob[i] = 0; oc[i] = 0; ox[i] = 0;
            snap[i] = 0; run[i] = 0; pos[i] = 0; md[i] = 0;
        end
        na = 1; nb = 2; nc = 2; nx = 2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_outs0", {20'd0, act[0]}, 32'd0);

        // quadratic A=1 B=2 C=2 x=2
        kick(1'b0, s);
        wait_idle();
        check("q_lat0", fimc[0] - s, 7);
        check("q_lat2", fimc[1] - s, 17);
        check("q_res0", {16'd0, res[0]}, 10);
        check("q_res2", {16'd0, res[1]}, 10);
        check("q_r1", {16'd0, r1[0]}, 4);

        // linear, same operands
        lhcnt = 0;
        kick(1'b1, s);
        wait_idle();
        check("l_lat0", fimc[0] - s, 4);
        check("l_lat2", fimc[1] - s, 8);
        check("l_res0", {16'd0, res[0]}, 6);
        check("l_nolh", lhcnt, 0);

        // A=3 B=0 C=5 x=3
        na = 3; nb = 0; nc = 5; nx = 3;
        kick(1'b0, s);
        wait_idle();
        check("w_lat2", fimc[1] - s, 17);
        check("w_res2", {16'd0, res[1]}, 32);
        check("w_res0", {16'd0, res[0]}, 32);

        // start pulse during SUM1 of the WAIT_CYC=0 instance
        na = 1; nb = 2; nc = 2; nx = 2;
        kick(1'b0, s);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("mid_lat0", fimc[0] - s, 7);

        // start held for 20 cycles
        held = 1'b1;
        lastfim0 = -1;
        start = 1'b1;
        modo = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b0;
        held = 1'b0;
        wait_idle();

        // reset during AXX, then a fresh run
        kick(1'b0, s);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort0", {20'd0, act[0]}, 32'd0);
        check("abort2", {20'd0, act[1]}, 32'd0);
        kick(1'b0, s);
        wait_idle();
        check("post_rst_res", {16'd0, res[0]}, 10);

        // randomized traffic
        repeat (600) begin
            start = ($urandom % 4) == 0;
            modo = 1'($urandom);
            na = 16'($urandom);
            nb = 16'($urandom);
            nc = 16'($urandom);
            nx = 16'($urandom);
            rst = ($urandom % 80) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
